muldiv_rsp_ctrl: RTL and testbench

//  Consumer end of the M-extension result channel (type_mul2lsu_s).
//  - Accepts an issue pulse from EXE and holds the pipeline stalled until the M-unit acks.
//  - Captures the result, tags it with rd and presents it to writeback.
//  - Sits between the M-unit output and the LSU/WB boundary.
//  - Guards against a lost ack with a timeout.

---
 rtl/muldiv_rsp_ctrl_pkg.sv | 21 ++
 rtl/muldiv_rsp_ctrl.sv | 123 ++++++++++++
 tb/tb_muldiv_rsp_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_rsp_ctrl_pkg.sv
// Shared M-extension response definitions: FSM state encoding, writeback record
// and default ack timeout used by the result-channel consumer.
package muldiv_rsp_ctrl_pkg;

   localparam int unsigned MDRSP_XLEN        = 32;
   localparam int unsigned MDRSP_RF_AW       = 5;
   localparam int unsigned MDRSP_ACK_TIMEOUT = 15;

   typedef enum logic [1:0] {
      MDRSP_IDLE = 2'b00,
      MDRSP_WAIT = 2'b01,
      MDRSP_DONE = 2'b10
   } type_mdrsp_state_e;

   typedef struct packed {
      logic                   valid;
      logic [MDRSP_RF_AW-1:0] rd;
      logic [MDRSP_XLEN-1:0]  data;
   } type_mdrsp2wb_s;

endpackage

// File: rtl/muldiv_rsp_ctrl.sv
// Consumer of the M-unit result channel: stalls the pipe while an op is in
// flight, captures the tagged result for writeback and aborts on a lost ack.
module muldiv_rsp_ctrl
   import muldiv_rsp_ctrl_pkg::*;
#(
   parameter int unsigned XLEN        = MDRSP_XLEN,
   parameter int unsigned RF_AW       = MDRSP_RF_AW,
   parameter int unsigned ACK_TIMEOUT = MDRSP_ACK_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_i,
   input  logic [RF_AW-1:0] issue_rd_i,
   input  logic             mul_req_i,
   input  logic [XLEN-1:0]  mul_result_i,
   input  logic             mul_ack_i,
   input  logic             flush_i,
   input  logic             wb_stall_i,
   output logic             stall_o,
   output logic             wb_valid_o,
   output logic [RF_AW-1:0] wb_rd_o,
   output logic [XLEN-1:0]  wb_data_o,
   output logic             busy_o,
   output logic             timeout_o
);

   localparam int unsigned     CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   type_mdrsp_state_e state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [RF_AW-1:0]  pend_rd;
   logic [RF_AW-1:0]  wb_rd_q;
   logic [XLEN-1:0]   wb_data_q;
   logic              timeout_q, timeout_nxt;
   logic              ack_ok, capture, latch_rd;

   assign ack_ok = mul_ack_i & mul_req_i;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      stall_o     = 1'b0;
      capture     = 1'b0;
      latch_rd    = 1'b0;
      timeout_nxt = 1'b0;
      if (flush_i) begin
         state_nxt = MDRSP_IDLE;
         cnt_nxt   = '0;
      end else begin
         unique case (state)
            MDRSP_IDLE: begin
               stall_o = issue_i;
               if (issue_i) begin
                  latch_rd  = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = MDRSP_WAIT;
               end
            end
            MDRSP_WAIT: begin
               stall_o = ~ack_ok;
               cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
               if (ack_ok) begin
                  capture   = 1'b1;
                  state_nxt = MDRSP_DONE;
               end else if (cnt == CNT_LAST) begin
                  timeout_nxt = 1'b1;
                  cnt_nxt     = '0;
                  state_nxt   = MDRSP_IDLE;
               end
            end
            MDRSP_DONE: begin
               // Issue during a writeback stall is held off by stall_o and re-presented.
               stall_o = wb_stall_i | issue_i;
               if (!wb_stall_i) begin
                  if (issue_i) begin
                     latch_rd  = 1'b1;
                     cnt_nxt   = '0;
                     state_nxt = MDRSP_WAIT;
                  end else begin
                     state_nxt = MDRSP_IDLE;
                  end
               end
            end
            default: state_nxt = MDRSP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MDRSP_IDLE;
         cnt       <= '0;
         pend_rd   <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
         if (latch_rd) pend_rd <= issue_rd_i;
         if (capture) begin
            wb_rd_q   <= pend_rd;
            wb_data_q <= mul_result_i;
         end
      end
   end

   assign wb_valid_o = (state == MDRSP_DONE) & ~flush_i;
   assign wb_rd_o    = wb_rd_q;
   assign wb_data_o  = wb_data_q;
   assign busy_o     = (state != MDRSP_IDLE);
   assign timeout_o  = timeout_q;

   a_issue_not_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
      issue_i |-> (state != MDRSP_WAIT));
   a_valid_only_done : assert property (@(posedge clk) disable iff (!rst_n)
      wb_valid_o |-> (state == MDRSP_DONE));
   a_no_stall_on_flush : assert property (@(posedge clk) disable iff (!rst_n)
      flush_i |-> !stall_o);

endmodule

// File: tb/tb_muldiv_rsp_ctrl.sv
// Directed bench for muldiv_rsp_ctrl: latency, back-to-back, writeback stall,
// flush, ack timeout and mid-op reset, against hand-computed expectations.
module tb_muldiv_rsp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_i;
   logic [4:0]  issue_rd_i;
   logic        mul_req_i;
   logic [31:0] mul_result_i;
   logic        mul_ack_i;
   logic        flush_i;
   logic        wb_stall_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        busy_o;
   logic        timeout_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned valid_cnt;

   always #5 clk = ~clk;

   muldiv_rsp_ctrl #(
      .XLEN        (32),
      .RF_AW       (5),
      .ACK_TIMEOUT (15)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_i      (issue_i),
      .issue_rd_i   (issue_rd_i),
      .mul_req_i    (mul_req_i),
      .mul_result_i (mul_result_i),
      .mul_ack_i    (mul_ack_i),
      .flush_i      (flush_i),
      .wb_stall_i   (wb_stall_i),
      .stall_o      (stall_o),
      .wb_valid_o   (wb_valid_o),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .busy_o       (busy_o),
      .timeout_o    (timeout_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then set for that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic iss, input logic [4:0] rd, input logic ack_req,
                        input logic [31:0] res);
      issue_i      = iss;
      issue_rd_i   = rd;
      mul_ack_i    = ack_req;
      mul_req_i    = ack_req;
      mul_result_i = res;
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; wb_stall_i = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 32'h0);
      repeat (3) tick();
      check("rst_valid", wb_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_data", wb_data_o, 0);
      check("rst_timeout", timeout_o, 0);
      rst_n = 1'b1;

      // 1: basic latency
      tick(); drive(1'b1, 5'd5, 1'b0, 32'h0); settle();
      check("t1_stall_T", stall_o, 1);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t1_stall_T1", stall_o, 1);
      check("t1_busy_T1", busy_o, 1);
      check("t1_valid_T1", wb_valid_o, 0);
      tick(); drive(1'b0, 5'd0, 1'b1, 32'h6); settle();
      check("t1_stall_T2", stall_o, 0);
      check("t1_valid_T2", wb_valid_o, 0);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t1_valid_T3", wb_valid_o, 1);
      check("t1_rd", wb_rd_o, 5);
      check("t1_data", wb_data_o, 32'h6);
      check("t1_stall_T3", stall_o, 0);
      tick(); settle();
      check("t1_valid_T4", wb_valid_o, 0);
      check("t1_busy_T4", busy_o, 0);
      check("t1_data_hold", wb_data_o, 32'h6);

      // 2: back-to-back
      tick(); drive(1'b1, 5'd3, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b1, 32'hA); settle();
      tick(); drive(1'b1, 5'd4, 1'b0, 32'h0); settle();
      check("t2_valid_a", wb_valid_o, 1);
      check("t2_rd_a", wb_rd_o, 3);
      check("t2_data_a", wb_data_o, 32'hA);
      check("t2_stall_done_issue", stall_o, 1);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t2_valid_wait", wb_valid_o, 0);
      check("t2_busy_wait", busy_o, 1);
      check("t2_data_hold", wb_data_o, 32'hA);
      tick(); drive(1'b0, 5'd0, 1'b1, 32'hB); settle();
      check("t2_stall_ack", stall_o, 0);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t2_valid_b", wb_valid_o, 1);
      check("t2_rd_b", wb_rd_o, 4);
      check("t2_data_b", wb_data_o, 32'hB);
      tick(); settle();
      check("t2_idle", busy_o, 0);

      // 3: writeback stall for 4 cycles
      tick(); drive(1'b1, 5'd7, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF); settle();
      valid_cnt = 0;
      for (int unsigned i = 0; i < 6; i++) begin
         tick(); drive(1'b0, 5'd0, 1'b0, 32'h0);
         wb_stall_i = (i < 4);
         settle();
         if (wb_valid_o) valid_cnt++;
         if (i < 5) begin
            check("t3_valid", wb_valid_o, 1);
            check("t3_data", wb_data_o, 32'hDEAD_BEEF);
            check("t3_rd", wb_rd_o, 7);
            check("t3_stall", stall_o, (i < 4) ? 1 : 0);
         end
      end
      check("t3_valid_cycles", valid_cnt, 5);
      check("t3_idle", busy_o, 0);
      wb_stall_i = 1'b0;

      // 4: flush coincident with ack
      tick(); drive(1'b1, 5'd9, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b1, 32'h55); flush_i = 1'b1; settle();
      check("t4_stall_flush", stall_o, 0);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); flush_i = 1'b0; settle();
      check("t4_busy", busy_o, 0);
      valid_cnt = 0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (wb_valid_o) valid_cnt++;
         tick(); settle();
      end
      check("t4_no_valid", valid_cnt, 0);
      check("t4_data_kept", wb_data_o, 32'hDEAD_BEEF);
      check("t4_rd_kept", wb_rd_o, 7);

      // 5: ack timeout; WAIT entered at cycle W = issue + 1
      tick(); drive(1'b1, 5'd1, 1'b0, 32'h0); settle();
      check("t5_timeout_T", timeout_o, 0);
      for (int unsigned k = 0; k < 15; k++) begin
         tick(); drive(1'b0, 5'd0, 1'b0, 32'h0);
         if (k == 3) mul_ack_i = 1'b1;
         settle();
         check("t5_timeout_pre", timeout_o, 0);
         check("t5_busy_pre", busy_o, 1);
      end
      tick(); mul_ack_i = 1'b0; settle();
      check("t5_timeout_pulse", timeout_o, 1);
      check("t5_busy_drop", busy_o, 0);
      check("t5_stall", stall_o, 0);
      check("t5_valid", wb_valid_o, 0);
      tick(); settle();
      check("t5_timeout_end", timeout_o, 0);

      // 6: reset mid-WAIT
      tick(); drive(1'b1, 5'd2, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t6_busy_wait", busy_o, 1);
      tick(); rst_n = 1'b0; settle();
      check("t6_rst_busy", busy_o, 0);
      check("t6_rst_stall", stall_o, 0);
      check("t6_rst_data", wb_data_o, 0);
      check("t6_rst_rd", wb_rd_o, 0);
      tick(); tick(); rst_n = 1'b1;
      tick(); drive(1'b1, 5'd6, 1'b0, 32'h0); settle();
      check("t6_stall_T", stall_o, 1);
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      tick(); drive(1'b0, 5'd0, 1'b1, 32'h1234); settle();
      tick(); drive(1'b0, 5'd0, 1'b0, 32'h0); settle();
      check("t6_valid", wb_valid_o, 1);
      check("t6_rd", wb_rd_o, 6);
      check("t6_data", wb_data_o, 32'h1234);
      tick(); settle();
      check("t6_idle", busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
